// File: rtl/labfinalsoc_nios2_gen2_0_cpu_debug_host_pkg.sv
// Shared types and constants for the debug-host virtual-JTAG scan engine.
// Default chain geometry matches the Nios II debug slave (38-bit DR, 2-bit IR).
package labfinalsoc_nios2_gen2_0_cpu_debug_host_pkg;

  localparam int DEFAULT_DR_WIDTH = 38;
  localparam int DEFAULT_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/labfinalsoc_nios2_gen2_0_cpu_debug_host_tckgen.sv
// TCK generator: TCK_DIV clk low then TCK_DIV clk high per period, idles low when !run.
// rise_pulse marks the first high clk; period_end_pulse marks the last clk of the period.
module labfinalsoc_nios2_gen2_0_cpu_debug_host_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic period_end_pulse
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_half_end;

  assign w_half_end = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!run) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_half_end) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // r_phase is already low whenever run is low, so TCK comes straight off a flop.
  assign tck              = r_phase;
  assign rise_pulse       = run & r_phase & (r_cnt == '0);
  assign period_end_pulse = run & r_phase & w_half_end;

endmodule

// File: rtl/labfinalsoc_nios2_gen2_0_cpu_debug_host_scan.sv
// Host-side virtual-JTAG scan engine: one (IR, DR) command at a time, response after
// 1 + (DR_WIDTH+3)*2*TCK_DIV clk; cmd_ready only in IDLE, commands never queued.
module labfinalsoc_nios2_gen2_0_cpu_debug_host_scan
  import labfinalsoc_nios2_gen2_0_cpu_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
  parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [DR_WIDTH-1:0] r_shift;
  logic [DR_WIDTH-1:0] r_cap;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_ir;
  logic [BW-1:0]       r_bit;
  logic                w_run;
  logic                w_rise;
  logic                w_pend;
  logic                w_accept;
  logic                w_last_bit;

  assign w_run      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_last_bit = (r_bit == LAST_BIT);

  labfinalsoc_nios2_gen2_0_cpu_debug_host_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk             (clk),
    .reset_n         (reset_n),
    .run             (w_run),
    .tck             (vji_tck),
    .rise_pulse      (w_rise),
    .period_end_pulse(w_pend)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    vji_tdi     = 1'b0;
    vji_uir     = 1'b0;
    vji_cdr     = 1'b0;
    vji_sdr     = 1'b0;
    vji_udr     = 1'b0;
    vji_rti     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        vji_rti   = 1'b1;
        if (cmd_valid) w_state_nxt = ST_UIR;
      end
      ST_UIR: begin
        vji_uir = 1'b1;
        if (w_pend) w_state_nxt = ST_CDR;
      end
      ST_CDR: begin
        vji_cdr = 1'b1;
        if (w_pend) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        vji_sdr = 1'b1;
        vji_tdi = r_shift[0];
        if (w_pend && w_last_bit) w_state_nxt = ST_UDR;
      end
      ST_UDR: begin
        vji_udr = 1'b1;
        if (w_pend) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0;
      r_cap    <= '0;
      r_rsp_dr <= '0;
      r_ir     <= '0;
      r_bit    <= '0;
    end else begin
      if (w_accept) begin
        r_ir    <= cmd_ir;
        r_shift <= cmd_dr;
        r_cap   <= '0;
        r_bit   <= '0;
      end
      if (r_state == ST_SHIFT) begin
        if (w_rise) r_cap[r_bit] <= vji_tdo;
        if (w_pend) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + BW'(1);
        end
      end
      // Load on entry to DONE so rsp_dr is already valid during the rsp_valid cycle.
      if ((r_state == ST_UDR) && w_pend) r_rsp_dr <= r_cap;
    end
  end

  assign rsp_dr    = r_rsp_dr;
  assign vji_ir_in = r_ir;

endmodule

// File: doc/labfinalsoc_nios2_gen2_0_cpu_debug_host_scan.md
# labfinalsoc_nios2_gen2_0_cpu_debug_host_scan

Host-side scan engine for the Nios II debug slave's virtual-JTAG interface, clocked from system `clk`. It accepts one (IR, DR) command at a time and generates TCK from `clk`. It drives the IR value and the UIR/CDR/SDR/UDR virtual-state strobes, shifts the DR out on TDI LSB-first and captures TDO into a response word. Used in simulation and on-chip self-test in place of the `sld_virtual_jtag_basic` hub.

## Interface
Parameters:
- `DR_WIDTH`, 38: scan chain length in bits.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_DIV`, 4: `clk` cycles per TCK half-period. Minimum 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ir`  in  IR_WIDTH  instruction: 0 OCIMEM, 1 TRACEMEM, 2 BREAK, 3 TRACECTRL.
- `cmd_dr`  in  DR_WIDTH  data shifted out, bit 0 first.
- `rsp_valid`  out  1  one-`clk` pulse; `rsp_dr` is valid.
- `rsp_dr`  out  DR_WIDTH  captured TDO bits, first bit in bit 0. Held until the next response.
- `vji_tck`  out  1  generated TCK.
- `vji_tdi`  out  1  serial data to the responder.
- `vji_tdo`  in  1  serial data from the responder.
- `vji_ir_in`  out  IR_WIDTH  latched instruction.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual JTAG state indicators.

## Operation
- States: IDLE, UIR, CDR, SHIFT, UDR, DONE.
- **IDLE**
  - `vji_rti`=1, `cmd_ready`=1, `vji_tck`=0.
  - On `cmd_valid & cmd_ready`, latch `cmd_ir` into `vji_ir_in` and `cmd_dr` into the shift register, then go to UIR.
- **UIR, CDR, each SHIFT bit, UDR**: each lasts exactly one TCK period (2·TCK_DIV `clk` cycles). The matching strobe is high for the whole period.
- **SHIFT**
  - A bit counter runs 0..DR_WIDTH-1.
  - `vji_tdi` = shift_reg[0], updated at each bit boundary.
  - On the `clk` where TCK rises, sample `vji_tdo` into capture bit [counter].
  - Shift right at the bit boundary.
  - After bit DR_WIDTH-1, go to UDR.
- **DONE**: `rsp_dr` <= capture; `rsp_valid`=1 for one `clk`; then IDLE.
- `vji_ir_in` holds its last value after DONE until the next command is accepted.
- `cmd_valid` outside IDLE is ignored; no queueing.
- While a command is in flight, `cmd_ir` and `cmd_dr` are don't-care; the block uses only its latched copies.
- `vji_tdi` is 0 outside SHIFT.

## Timing
- **TCK generation**
  - Half-period counter 0..TCK_DIV-1 runs only outside IDLE and DONE.
  - Each TCK period: TCK_DIV cycles low, then TCK_DIV cycles high.
  - The rising edge falls mid-period. The state/bit boundary coincides with the falling edge, so strobes and TDI change only while TCK falls.
- **Latency**: command accepted at cycle 0 → UIR begins at cycle 1 → `rsp_valid` at cycle 1 + (DR_WIDTH+3)·2·TCK_DIV. With defaults this is cycle 329.
- `cmd_ready` returns high the cycle after `rsp_valid`. Minimum command spacing is the latency + 1.
- **Reset values**:
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_dr`=0.
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0.
  - `vji_uir`/`cdr`/`sdr`/`udr`=0, `vji_rti`=1.
- **Reset mid-operation**: the command is aborted immediately. No `rsp_valid` is produced, `rsp_dr` is cleared and TCK is forced low.
- **TCK_DIV=1**: TCK toggles every `clk`. TDO is still sampled on the rising-edge cycle.

## Structure
- Package `labfinalsoc_nios2_gen2_0_cpu_debug_host_pkg` holds:
  - the state enum;
  - IR code constants (OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3);
  - the default `DR_WIDTH`/`IR_WIDTH` values.
- Sub-module `labfinalsoc_nios2_gen2_0_cpu_debug_host_tckgen`:
  - Parameter: `TCK_DIV`.
  - Inputs: `run`.
  - Outputs: `tck`, `rise_pulse`, `period_end_pulse`.
  - The top-level FSM advances only on `period_end_pulse`.

## Test plan
- **Loopback** (`vji_tdo`=`vji_tdi`): `cmd_ir`=2, `cmd_dr`=0x2A_5A5A_5A5A → `rsp_dr`=0x2A_5A5A_5A5A, `rsp_valid` at cycle 329, `vji_ir_in`=2 from cycle 1.
- **TDO tied 1**, `cmd_dr`=0 → `rsp_dr`=0x3F_FFFF_FFFF; `vji_tdi` stays 0 throughout.
- **Strobe sequence**: check UIR, CDR, SDR (38 TCK periods) and UDR are each exclusive and high for exactly 8·n `clk`; exactly 41 TCK rising edges per command.
- **Back-to-back commands**: `cmd_valid` held high → second accept exactly 1 cycle after the first `rsp_valid`; `cmd_valid` pulses during the busy window are ignored.
- **Reset mid-SHIFT**: assert `reset_n`=0 at bit 10 → all outputs at reset values immediately, no `rsp_valid`, and the next command completes normally.
- **TCK_DIV=1** loopback with `cmd_dr`=0x00_0000_0001 → `rsp_dr`=0x00_0000_0001, `rsp_valid` at cycle 83.
